// File: rtl/da_pkg.sv
`default_nettype none
// ============================================================================
// da_pkg : shared types and helpers for the distributed-arithmetic sequencer.
// Rev 1.0
// ============================================================================
package da_pkg;

   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_RELOAD = 3'd1,
      ST_IDLE   = 3'd2,
      ST_RUN    = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_HOLD   = 3'd5
   } da_state_e;

   function automatic int lut_w(input int data_width_b, input int k);
      return data_width_b + $clog2(k) + 1;
   endfunction

   function automatic int acc_w(input int data_width_b, input int k, input int w);
      return lut_w(data_width_b, k) + w + 1;
   endfunction

   // Returns {inv, addr}: the top plane bit selects the mirrored half of the LUT.
   function automatic logic [32:0] fold(input logic [31:0] plane, input int k);
      logic        inv;
      logic [31:0] mask;
      inv  = |((plane >> (k - 1)) & 32'd1);
      mask = (32'd1 << (k - 1)) - 32'd1;
      return {inv, (plane ^ {32{inv}}) & mask};
   endfunction

endpackage
`default_nettype wire

// File: rtl/da_plane_gen.sv
`default_nettype none
// ============================================================================
// da_plane_gen : MSB-first bit-plane extraction and LUT address folding.
// Rev 1.0
// ============================================================================
module da_plane_gen
   import da_pkg::*;
#(
   parameter int K = 8,
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           run,
   input  logic [K*W-1:0] x,
   output logic [K-2:0]   lut_addr,
   output logic           lut_inv,
   output logic           first,
   output logic           last
);
   localparam int C_CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [C_CW-1:0] C_TOP = C_CW'(W - 1);

   logic [C_CW-1:0] r_plane;
   logic [K-1:0]    w_plane;
   logic [32:0]     w_fold;
   logic            w_unused_fold;

   // Counter parks on the MSB plane whenever the sequencer is not running.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_plane <= C_TOP;
      end else if (!run) begin
         r_plane <= C_TOP;
      end else if (r_plane != '0) begin
         r_plane <= r_plane - 1'b1;
      end
   end

   for (genvar i = 0; i < K; i++) begin : g_plane
      logic [W-1:0] w_word;
      assign w_word     = x[i*W +: W];
      assign w_plane[i] = w_word[r_plane];
   end

   assign w_fold        = fold(32'(w_plane), K);
   assign w_unused_fold = ^w_fold[31:K-1];

   assign lut_addr = run ? w_fold[K-2:0] : '0;
   assign lut_inv  = run ? w_fold[32] : 1'b0;
   assign first    = (r_plane == C_TOP);
   assign last     = (r_plane == '0);

endmodule
`default_nettype wire

// File: rtl/da_seq_ctrl.sv
`default_nettype none
// ============================================================================
// da_seq_ctrl : bit-serial DA dot-product sequencer with periodic LUT reload.
// Define DA_SEQ_SAT_EN to saturate the result instead of wrapping. Rev 1.0
// ============================================================================
module da_seq_ctrl
   import da_pkg::*;
#(
   parameter int K             = 8,
   parameter int DATA_WIDTH_B  = 8,
   parameter int DATA_WIDTH_X  = 8,
   parameter int UPDATE_PERIOD = 16,
   parameter int OUT_W         = 16
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      in_valid,
   output logic                                      in_ready,
   input  logic [K*DATA_WIDTH_X-1:0]                 x_in,
   output logic [K-2:0]                              lut_addr,
   output logic                                      lut_inv,
   input  logic signed [lut_w(DATA_WIDTH_B, K)-1:0]  lut_data,
   output logic                                      update_pulse,
   input  logic                                      gen_done,
   output logic                                      out_valid,
   input  logic                                      out_ready,
   output logic signed [OUT_W-1:0]                   result
);
   localparam int C_W     = DATA_WIDTH_X;
   localparam int C_LUT_W = lut_w(DATA_WIDTH_B, K);
   localparam int C_ACC_W = acc_w(DATA_WIDTH_B, K, DATA_WIDTH_X);
   localparam int C_CNT_W = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
   localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(UPDATE_PERIOD - 1);

   da_state_e                  r_state;
   da_state_e                  w_state_nxt;
   logic [K*C_W-1:0]           r_x;
   logic [C_CNT_W-1:0]         r_cnt;
   logic signed [C_ACC_W-1:0]  r_acc;
   logic signed [C_ACC_W-1:0]  w_data_ext;
   logic signed [C_ACC_W-1:0]  w_term;
   logic                       r_term_vld;
   logic                       r_term_first;
   logic                       r_inv_d;
   logic                       w_run;
   logic                       w_plane_first;
   logic                       w_plane_last;
   logic                       w_accept_in;
   logic                       w_accept_out;

   assign w_run        = (r_state == ST_RUN);
   assign w_accept_in  = (r_state == ST_IDLE) && in_valid;
   assign w_accept_out = (r_state == ST_HOLD) && out_ready;

   da_plane_gen #(
      .K (K),
      .W (C_W)
   ) u_plane_gen (
      .clk      (clk),
      .rst      (rst),
      .run      (w_run),
      .x        (r_x),
      .lut_addr (lut_addr),
      .lut_inv  (lut_inv),
      .first    (w_plane_first),
      .last     (w_plane_last)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_INIT:   w_state_nxt = ST_RELOAD;
         ST_RELOAD: if (gen_done) w_state_nxt = ST_IDLE;
         ST_IDLE:   if (in_valid) w_state_nxt = ST_RUN;
         ST_RUN:    if (w_plane_last) w_state_nxt = ST_DRAIN;
         ST_DRAIN:  w_state_nxt = ST_HOLD;
         ST_HOLD:   if (out_ready) w_state_nxt = (r_cnt == C_CNT_LAST) ? ST_INIT : ST_IDLE;
         default:   w_state_nxt = ST_INIT;
      endcase
   end

   // LUT data lags the issued address by one cycle, so the fold flag is delayed to match.
   assign w_data_ext = {{(C_ACC_W - C_LUT_W){lut_data[C_LUT_W-1]}}, lut_data};
   assign w_term     = r_inv_d ? -w_data_ext : w_data_ext;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_INIT;
         r_x          <= '0;
         r_cnt        <= '0;
         r_acc        <= '0;
         r_term_vld   <= 1'b0;
         r_term_first <= 1'b0;
         r_inv_d      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_term_vld   <= w_run;
         r_term_first <= w_run && w_plane_first;
         r_inv_d      <= lut_inv;
         if (w_accept_in) begin
            r_x <= x_in;
         end
         if (w_accept_out) begin
            r_cnt <= (r_cnt == C_CNT_LAST) ? '0 : r_cnt + 1'b1;
         end
         // The sign plane carries negative weight in two's complement.
         if (r_term_vld) begin
            r_acc <= r_term_first ? -w_term : (r_acc <<< 1) + w_term;
         end
      end
   end

   assign in_ready     = (r_state == ST_IDLE);
   assign out_valid    = (r_state == ST_HOLD);
   assign update_pulse = (r_state == ST_INIT) && !rst;

`ifdef DA_SEQ_SAT_EN
   logic w_ovf;
   assign w_ovf = !((&r_acc[C_ACC_W-1:OUT_W-1]) || !(|r_acc[C_ACC_W-1:OUT_W-1]));
   always_comb begin
      result = r_acc[OUT_W-1:0];
      if (w_ovf) begin
         result = r_acc[C_ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end
   end
`else
   logic w_unused_acc_hi;
   assign w_unused_acc_hi = ^r_acc[C_ACC_W-1:OUT_W];
   assign result          = r_acc[OUT_W-1:0];
`endif

endmodule
`default_nettype wire
